// File: rtl/fpcvt_wb_queue.sv
// Writeback queue between the FP-to-int converter and the integer writeback port.
// Optional same-cycle bypass when empty: define FPCVT_WBQ_BYPASS_EN.
module fpcvt_wb_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_en,
  input  logic [63:0]        in_res,
  input  logic               in_alt,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [10:0]        in_flag,
  input  logic               flush,
  input  logic               out_rdy,
  output logic               out_en,
  output logic [63:0]        out_res,
  output logic               out_alt,
  output logic [TAG_W-1:0]   out_tag,
  output logic [10:0]        out_flag,
  output logic               stall,
  output logic [$clog2(DEPTH):0] cnt,
  output logic               ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 64 + 1 + TAG_W + 11;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_THR  = (AW+1)'(DEPTH - 1);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic [EW-1:0] w_in, w_head, w_out;
  logic          w_nonempty, w_full, w_qpop, w_push, w_drop;

  assign w_in       = {in_res, in_alt, in_tag, in_flag};
  assign w_head     = r_mem[r_rd];
  assign w_nonempty = (r_cnt != '0);
  assign w_full     = (r_cnt == L_FULL);
  // Only stored entries are popped; a bypassed result never touches the array.
  assign w_qpop     = w_nonempty & out_rdy;
  assign w_drop     = in_en & ~flush & w_full & ~w_qpop;

`ifdef FPCVT_WBQ_BYPASS_EN
  logic w_byp;
  assign w_byp  = ~w_nonempty & in_en & ~flush;
  assign w_push = in_en & ~flush & (~w_full | w_qpop) & ~(w_byp & out_rdy);
  assign w_out  = w_nonempty ? w_head : (w_byp ? w_in : '0);
  assign out_en = w_nonempty | w_byp;
`else
  assign w_push = in_en & ~flush & (~w_full | w_qpop);
  assign w_out  = w_nonempty ? w_head : '0;
  assign out_en = w_nonempty;
`endif

  assign {out_res, out_alt, out_tag, out_flag} = w_out;
  assign stall = (r_cnt >= L_THR);
  assign cnt   = r_cnt;
  assign ovf   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (flush) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_qpop) r_rd <= r_rd + 1'b1;
        case ({w_push, w_qpop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Storage holds no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_in;
  end
endmodule

// File: tb/tb_fpcvt_wb_queue.sv
// Self-checking bench for fpcvt_wb_queue: directed table, corner sequences, random vs queue model.
module tb_fpcvt_wb_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 9;

  logic clk = 1'b0;
  logic rst;
  logic in_en, in_alt, flush, out_rdy;
  logic [63:0] in_res;
  logic [TAG_W-1:0] in_tag;
  logic [10:0] in_flag;
  logic out_en, out_alt, stall, ovf;
  logic [63:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic [10:0] out_flag;
  logic [$clog2(DEPTH):0] cnt;

  fpcvt_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_res(in_res), .in_alt(in_alt),
    .in_tag(in_tag), .in_flag(in_flag), .flush(flush), .out_rdy(out_rdy),
    .out_en(out_en), .out_res(out_res), .out_alt(out_alt), .out_tag(out_tag),
    .out_flag(out_flag), .stall(stall), .cnt(cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res; logic alt; logic [TAG_W-1:0] tag; logic [10:0] flag;
  } ent_t;
  ent_t q[$];
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endfunction

  task automatic model_check();
    chk("m_cnt", 64'(cnt), 64'(q.size()));
    chk("m_out_en", 64'(out_en), 64'(q.size() > 0));
    chk("m_stall", 64'(stall), 64'(q.size() >= DEPTH - 1));
    chk("m_ovf", 64'(ovf), 64'(m_ovf));
    if (q.size() > 0) begin
      chk("m_res", out_res, q[0].res);
      chk("m_tag", 64'(out_tag), 64'(q[0].tag));
      chk("m_alt", 64'(out_alt), 64'(q[0].alt));
      chk("m_flag", 64'(out_flag), 64'(q[0].flag));
    end else begin
      chk("m_zero", {out_res[62:0], out_alt} ^ 64'(out_tag) ^ 64'(out_flag), 64'd0);
      chk("m_res0", out_res, 64'd0);
    end
  endtask

  // One clock: apply inputs, advance the model, check outputs after the edge.
  task automatic step(bit en, logic [63:0] res, bit alt, logic [TAG_W-1:0] tag,
                      logic [10:0] flg, bit rdy, bit fl);
    ent_t e;
    bit pop, full;
    in_en = en; in_res = res; in_alt = alt; in_tag = tag; in_flag = flg;
    out_rdy = rdy; flush = fl;
    e.res = res; e.alt = alt; e.tag = tag; e.flag = flg;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (en && full && !pop) m_ovf = 1'b1;
      if (pop) void'(q.pop_front());
      if (en && (!full || pop)) q.push_back(e);
    end
    model_check();
  endtask

  task automatic idle_all();
    in_en = 0; in_res = '0; in_alt = 0; in_tag = '0; in_flag = '0;
    out_rdy = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit en; logic [TAG_W-1:0] tag; bit rdy; bit fl;
    int e_cnt; bit e_en; logic [TAG_W-1:0] e_tag; bit e_stall; bit e_ovf;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 9'd1, 0, 0, 1, 1, 9'd1, 0, 0};
    tbl[1] = '{1, 9'd2, 0, 0, 2, 1, 9'd1, 0, 0};
    tbl[2] = '{1, 9'd3, 0, 0, 3, 1, 9'd1, 1, 0};
    tbl[3] = '{1, 9'd4, 0, 0, 4, 1, 9'd1, 1, 0};
    tbl[4] = '{1, 9'd5, 0, 0, 4, 1, 9'd1, 1, 1};
    tbl[5] = '{0, 9'd0, 1, 0, 3, 1, 9'd2, 1, 1};
    tbl[6] = '{0, 9'd0, 1, 0, 2, 1, 9'd3, 0, 1};
    tbl[7] = '{0, 9'd0, 1, 0, 1, 1, 9'd4, 0, 1};
    tbl[8] = '{0, 9'd0, 1, 0, 0, 0, 9'd0, 0, 1};

    idle_all();
    rst = 1'b1;
    #1;
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_out_en", 64'(out_en), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); m_ovf = 0;

    // Fill to full, overflow, then drain in order.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, 64'(tbl[i].tag), 1'b0, tbl[i].tag, 11'd0, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_en", i), 64'(out_en), 64'(tbl[i].e_en));
      chk($sformatf("tbl%0d_tag", i), 64'(out_tag), 64'(tbl[i].e_tag));
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].e_ovf));
    end

    // Asynchronous reset with entries queued and ovf set.
    for (int i = 0; i < 3; i++) step(1, 64'(i), 0, 9'(i), 11'd0, 0, 0);
    idle_all();
    rst = 1'b1;
    #1;
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_out_en", 64'(out_en), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_res", out_res, 64'd0);
    q.delete(); m_ovf = 0;
    @(posedge clk); #1 rst = 1'b0;

    // Single op, one-cycle latency.
    step(1, 64'h0000_0000_FFFF_FFFF, 1, 9'h05A, 11'h7FF, 1, 0);
    chk("single_en", 64'(out_en), 64'd1);
    chk("single_res", out_res, 64'h0000_0000_FFFF_FFFF);
    chk("single_tag", 64'(out_tag), 64'h05A);
    step(0, 64'd0, 0, 9'd0, 11'd0, 1, 0);
    chk("single_cnt", 64'(cnt), 64'd0);

    // Push and pop while full.
    for (int i = 1; i <= 4; i++) step(1, 64'(i), 0, 9'(i), 11'd0, 0, 0);
    step(1, 64'd9, 0, 9'd9, 11'd0, 1, 0);
    chk("fullpp_cnt", 64'(cnt), 64'd4);
    chk("fullpp_ovf", 64'(ovf), 64'd0);
    chk("fullpp_head", 64'(out_tag), 64'd2);
    for (int i = 0; i < 4; i++) begin
      step(0, 64'd0, 0, 9'd0, 11'd0, 1, 0);
      if (i == 2) chk("fullpp_last", 64'(out_tag), 64'd9);
    end
    chk("fullpp_empty", 64'(cnt), 64'd0);

    // Flush overrides concurrent push and pop.
    for (int i = 0; i < 3; i++) step(1, 64'(i + 20), 0, 9'(i + 20), 11'd0, 0, 0);
    step(1, 64'hDEAD, 0, 9'h1FF, 11'd0, 1, 1);
    chk("flush_cnt", 64'(cnt), 64'd0);
    chk("flush_en", 64'(out_en), 64'd0);
    chk("flush_res", out_res, 64'd0);
    step(0, 64'd0, 0, 9'd0, 11'd0, 1, 0);
    chk("flush_nowrite", 64'(out_en), 64'd0);

    // Wrap: streaming push/pop, pointers go round twice.
    for (int i = 0; i < 10; i++) begin
      step(1, 64'(i), 0, 9'(i), 11'd0, 1, 0);
      chk($sformatf("wrap%0d", i), out_res, 64'(i));
    end
    step(0, 64'd0, 0, 9'd0, 11'd0, 1, 0);
    chk("wrap_empty", 64'(cnt), 64'd0);

    // Random traffic against the queue model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom}, 1'($urandom), 9'($urandom),
           11'($urandom), ($urandom % 100) < ((k % 200) < 100 ? 30 : 75),
           ($urandom % 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
